// File: rtl/e200_cmt_perf_mon_if.sv
`default_nettype none
// ============================================================================
// Module   : e200_cmt_perf_mon_if
// Brief    : Commit-stream bus observed by the E200 performance monitor.
// Revision : 1.0
// ============================================================================
interface e200_cmt_perf_mon_if #(
  parameter int unsigned PC_W = 32
);
  logic            cmt_valid;
  logic [PC_W-1:0] cmt_pc;

  modport master (output cmt_valid, output cmt_pc);
  modport slave  (input  cmt_valid, input  cmt_pc);
endinterface
`default_nettype wire

// File: rtl/e200_cmt_perf_mon.sv
`default_nettype none
// ============================================================================
// Module   : e200_cmt_perf_mon
// Brief    : Commit-stream cycle/instret/watchpoint counters with end-of-test
//            detection on watchpoint 0 and sticky pass/fail sampling.
// Revision : 1.0
// ============================================================================
module e200_cmt_perf_mon #(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_WP   = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PASS_VAL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     clr,
  e200_cmt_perf_mon_if.slave       cmt,
  input  logic [NUM_WP-1:0]        wp_en,
  input  logic [NUM_WP*PC_W-1:0]   wp_addr,
  input  logic [CNT_W-1:0]         end_hits,
  input  logic [XLEN-1:0]          result_val,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         instret_cnt,
  output logic [NUM_WP*CNT_W-1:0]  wp_hit_cnt,
  output logic [NUM_WP*CNT_W-1:0]  wp_first_cyc,
  output logic [NUM_WP-1:0]        wp_seen,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [XLEN-1:0]  c_pass    = XLEN'(PASS_VAL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_fail;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_instret_cnt;

  logic [NUM_WP-1:0] w_hit;
  logic              w_run;
  logic [CNT_W-1:0]  w_hit0_nxt;
  logic              w_end;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + c_cnt_one;
  endfunction

  assign w_run = (r_state == ST_RUN);

  // Wrapping add is intentional: a saturated count gives 0, which never
  // equals a non-zero end_hits, so end detection stays disabled there.
  assign w_hit0_nxt = wp_hit_cnt[CNT_W-1:0] + c_cnt_one;
  assign w_end      = w_hit[0] && (end_hits != '0) && (w_hit0_nxt == end_hits);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else if (clr) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_end) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (result_val == c_pass);
            r_fail  <= (result_val != c_pass);
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else if (clr) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else if (w_run) begin
      r_cycle_cnt <= sat_inc(r_cycle_cnt);
      if (cmt.cmt_valid) begin
        r_instret_cnt <= sat_inc(r_instret_cnt);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_WP; gi++) begin : g_wp
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_first_cyc;
    logic             r_seen;

    assign w_hit[gi] = w_run & cmt.cmt_valid & wp_en[gi] &
                       (cmt.cmt_pc == wp_addr[gi*PC_W +: PC_W]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_hit_cnt   <= '0;
        r_first_cyc <= '0;
        r_seen      <= 1'b0;
      end else if (clr) begin
        r_hit_cnt   <= '0;
        r_first_cyc <= '0;
        r_seen      <= 1'b0;
      end else if (w_hit[gi]) begin
        r_hit_cnt <= sat_inc(r_hit_cnt);
        if (!r_seen) begin
          r_first_cyc <= r_cycle_cnt;
          r_seen      <= 1'b1;
        end
      end
    end

    assign wp_hit_cnt[gi*CNT_W +: CNT_W]   = r_hit_cnt;
    assign wp_first_cyc[gi*CNT_W +: CNT_W] = r_first_cyc;
    assign wp_seen[gi]                     = r_seen;
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_e200_cmt_perf_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_e200_cmt_perf_mon
// Brief    : Directed bench with a cycle-level reference model of the monitor.
// Revision : 1.0
// ============================================================================
module tb_e200_cmt_perf_mon;

  localparam logic [31:0] WP0   = 32'h8000_003e;
  localparam longint      MAXC  = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (default parameters)
  logic          start = 1'b0;
  logic          clr   = 1'b0;
  logic [3:0]    wp_en = 4'b0;
  logic [127:0]  wp_addr = '0;
  logic [31:0]   end_hits = '0;
  logic [31:0]   result_val = '0;
  logic [31:0]   cycle_cnt, instret_cnt;
  logic [127:0]  wp_hit_cnt, wp_first_cyc;
  logic [3:0]    wp_seen;
  logic          busy, done, pass, fail;

  e200_cmt_perf_mon_if #(.PC_W(32)) cif ();

  e200_cmt_perf_mon dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .cmt(cif),
    .wp_en(wp_en), .wp_addr(wp_addr), .end_hits(end_hits), .result_val(result_val),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .wp_hit_cnt(wp_hit_cnt),
    .wp_first_cyc(wp_first_cyc), .wp_seen(wp_seen), .busy(busy), .done(done),
    .pass(pass), .fail(fail)
  );

  // Narrow-counter DUT for saturation
  logic          start_s = 1'b0;
  logic [3:0]    cyc_s, ins_s, hit_s, first_s;
  logic          seen_s, busy_s, done_s, pass_s, fail_s;

  e200_cmt_perf_mon_if #(.PC_W(32)) cif_s ();

  e200_cmt_perf_mon #(.NUM_WP(1), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .clr(1'b0), .cmt(cif_s),
    .wp_en(1'b1), .wp_addr(32'h0000_1000), .end_hits(4'd0), .result_val(32'd1),
    .cycle_cnt(cyc_s), .instret_cnt(ins_s), .wp_hit_cnt(hit_s),
    .wp_first_cyc(first_s), .wp_seen(seen_s), .busy(busy_s), .done(done_s),
    .pass(pass_s), .fail(fail_s)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase flags plus plain integer tallies.
  logic   m_run, m_done, m_pass, m_fail;
  longint m_cyc, m_ins;
  longint m_hits [4];
  longint m_first[4];
  logic [3:0] m_seen;

  function automatic longint inc(input longint v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic hitv [4];
    if (rst || clr) begin
      m_run <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0; m_fail <= 1'b0;
      m_cyc <= 0; m_ins <= 0; m_seen <= '0;
      for (int i = 0; i < 4; i++) begin
        m_hits[i]  <= 0;
        m_first[i] <= 0;
      end
    end else if (!m_run && !m_done) begin
      if (start) m_run <= 1'b1;
    end else if (m_run) begin
      m_cyc <= inc(m_cyc);
      if (cif.cmt_valid) m_ins <= inc(m_ins);
      for (int i = 0; i < 4; i++) begin
        hitv[i] = cif.cmt_valid && wp_en[i] && (cif.cmt_pc == wp_addr[i*32 +: 32]);
        if (hitv[i]) begin
          m_hits[i] <= inc(m_hits[i]);
          if (!m_seen[i]) begin
            m_first[i] <= m_cyc;
            m_seen[i]  <= 1'b1;
          end
        end
      end
      if (hitv[0] && end_hits != 0 && m_hits[0] + 1 == longint'(end_hits)) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
        m_pass <= (result_val == 32'd1);
        m_fail <= (result_val != 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("pass", pass, m_pass);
      chk("fail", fail, m_fail);
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("instret_cnt", instret_cnt, m_ins);
      chk("wp_seen", wp_seen, m_seen);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("wp_hit_cnt%0d", i), wp_hit_cnt[i*32 +: 32], m_hits[i]);
        chk($sformatf("wp_first_cyc%0d", i), wp_first_cyc[i*32 +: 32], m_first[i]);
      end
    end
  end

  task automatic drv(input logic s, input logic c, input logic v, input logic [31:0] pc);
    @(negedge clk);
    start = s; clr = c; cif.cmt_valid = v; cif.cmt_pc = pc;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic run_eight();
    drv(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 3; j++) drv(0, 0, 1, 32'h8000_0000 + 32'(4 * j));
      drv(0, 0, 1, WP0);
    end
    drv(0, 0, 0, 0);
    drv(0, 0, 0, 0);
    after_edge();
  endtask

  function automatic logic any_out();
    return |{cycle_cnt, instret_cnt, wp_hit_cnt, wp_first_cyc, wp_seen, busy, done, pass, fail};
  endfunction

  initial begin
    cif.cmt_valid = 1'b0; cif.cmt_pc = '0;
    cif_s.cmt_valid = 1'b0; cif_s.cmt_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_all_zero", any_out(), 0);
    #1 rst = 1'b0;

    // Basic end, pass
    wp_en = 4'b0001; wp_addr[31:0] = WP0; end_hits = 32'd8; result_val = 32'd1;
    run_eight();
    chk("basic_done", done, 1);
    chk("basic_pass", pass, 1);
    chk("basic_fail", fail, 0);
    chk("basic_hit0", wp_hit_cnt[31:0], 8);
    chk("basic_instret", instret_cnt, 32);
    chk("basic_cycle", cycle_cnt, 32);
    chk("basic_first0", wp_first_cyc[31:0], 3);

    // Fail path, flags stick after result changes
    drv(0, 1, 0, 0);
    result_val = 32'd5;
    run_eight();
    result_val = 32'd1;
    drv(0, 0, 0, 0); drv(0, 0, 0, 0);
    after_edge();
    chk("failpath_fail", fail, 1);
    chk("failpath_pass", pass, 0);
    chk("failpath_done", done, 1);

    // Commit qualification
    drv(0, 1, 0, 0);
    end_hits = 32'd0;
    drv(1, 0, 0, 0);
    repeat (10) drv(0, 0, 0, WP0);
    drv(0, 0, 1, WP0);
    after_edge();
    chk("qual_hit0", wp_hit_cnt[31:0], 1);
    chk("qual_instret", instret_cnt, 1);
    chk("qual_cycle", cycle_cnt, 11);

    // Multi-watchpoint
    drv(0, 1, 0, 0);
    wp_en = 4'b0111;
    wp_addr[32 +: 32] = 32'h1000; wp_addr[64 +: 32] = 32'h1000; wp_addr[96 +: 32] = 32'h1000;
    drv(1, 0, 0, 0);
    repeat (5) drv(0, 0, 1, 32'h2000);
    drv(0, 0, 1, 32'h1000);
    after_edge();
    chk("multi_hit1", wp_hit_cnt[32 +: 32], 1);
    chk("multi_hit2", wp_hit_cnt[64 +: 32], 1);
    chk("multi_hit3", wp_hit_cnt[96 +: 32], 0);
    chk("multi_first1", wp_first_cyc[32 +: 32], 5);
    chk("multi_first2", wp_first_cyc[64 +: 32], 5);
    chk("multi_seen", wp_seen, 4'b0110);
    drv(0, 0, 0, 0);

    // Saturation on the narrow instance
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    repeat (24) @(negedge clk);
    chk("sat_cycle", cyc_s, 15);
    chk("sat_done", done_s, 0);
    chk("sat_busy", busy_s, 1);

    // clr + start from DONE
    drv(0, 1, 0, 0);
    wp_en = 4'b0001; end_hits = 32'd2; result_val = 32'd1;
    drv(1, 0, 0, 0);
    drv(0, 0, 1, WP0);
    drv(0, 0, 1, WP0);
    drv(0, 0, 0, 0);
    after_edge();
    chk("pre_clr_done", done, 1);
    drv(1, 1, 0, 0);
    after_edge();
    chk("clr_start_all_zero", any_out(), 0);

    // Asynchronous reset mid-RUN, then restart
    drv(1, 0, 0, 0);
    drv(0, 0, 1, 32'h4000);
    drv(0, 0, 1, 32'h4000);
    after_edge();
    chk("pre_rst_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_all_zero", any_out(), 0);
    rst = 1'b0;
    drv(1, 0, 0, 0);
    repeat (3) drv(0, 0, 1, 32'h4000);
    after_edge();
    chk("restart_instret", instret_cnt, 3);
    chk("restart_cycle", cycle_cnt, 3);
    drv(0, 0, 0, 0);
    drv(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/e200_cmt_perf_mon.md
# e200_cmt_perf_mon

Synthesisable commit-stream performance monitor and test-end detector for the E200 simulation/FPGA harness. It sits beside the core and observes the EXU commit handshake and committed PC. It counts cycles, retired instructions and per-watchpoint PC hits across `NUM_WP` programmable watchpoints. After a programmable number of hits on watchpoint 0, it declares end-of-test and samples a result register into sticky pass/fail flags.

## Interface
Parameters:
- `PC_W`, 32, committed PC width
- `XLEN`, 32, result value width
- `NUM_WP`, 4, number of PC watchpoints (1..8)
- `CNT_W`, 32, width of every counter
- `PASS_VAL`, 1, result value meaning pass

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  pulse; IDLE→RUN
- `clr`  in  1  synchronous clear; any state→IDLE, all counters and flags to 0
- `cmt_valid`  in  1  instruction commits this cycle (valid & ready already ANDed)
- `cmt_pc`  in  PC_W  PC of committing instruction; don't-care when `cmt_valid`=0
- `wp_en`  in  NUM_WP  per-watchpoint enable
- `wp_addr`  in  NUM_WP*PC_W  watchpoint addresses; watchpoint i at bits [i*PC_W +: PC_W]
- `end_hits`  in  CNT_W  watchpoint-0 hit count that ends the test; 0 disables end detection
- `result_val`  in  XLEN  result register (e.g. x3), sampled at end
- `cycle_cnt`  out  CNT_W  cycles spent in RUN
- `instret_cnt`  out  CNT_W  commits in RUN
- `wp_hit_cnt`  out  NUM_WP*CNT_W  per-watchpoint hit counts
- `wp_first_cyc`  out  NUM_WP*CNT_W  `cycle_cnt` value at each watchpoint's first hit
- `wp_seen`  out  NUM_WP  sticky first-hit flag per watchpoint
- `busy`  out  1  state==RUN
- `done`  out  1  state==DONE
- `pass`  out  1  sticky; `result_val`==PASS_VAL at end
- `fail`  out  1  sticky; `result_val`!=PASS_VAL at end

## Operation
- FSM with states IDLE, RUN, DONE; reset state IDLE.
  - IDLE: `start`→RUN.
  - RUN: end event→DONE.
  - DONE: holds until `clr` or `rst`.
  - `clr` takes priority over every transition. `start` outside IDLE is ignored.
- Hit on watchpoint i: state==RUN & `cmt_valid` & `wp_en[i]` & `cmt_pc`==`wp_addr[i]`.
  - Several watchpoints may hit in the same cycle; each counts independently.
  - Only committed instructions count. A PC that sits unchanged while `cmt_valid`=0 does not count.
- Counters in RUN:
  - `cycle_cnt` +1 every cycle.
  - `instret_cnt` +1 per `cmt_valid`.
  - `wp_hit_cnt[i]` +1 per hit.
  - All counters saturate at all-ones and never wrap.
- First hit of watchpoint i (`wp_seen[i]`=0): load `wp_first_cyc[i]` with the current (pre-increment) `cycle_cnt`, and set `wp_seen[i]`.
- End event: watchpoint-0 hit while `end_hits`!=0 and `wp_hit_cnt[0]`+1 == `end_hits`.
  - In that same cycle, `result_val` is sampled; `pass` or `fail` is set accordingly, never both.
  - The end-event cycle itself is fully counted: cycle, instret and hits.
- In IDLE and DONE all counters and first-cycle registers hold. Outputs stay readable in DONE.
- `end_hits` is quasi-static during RUN. If `end_hits` ≤ the current count, no end event occurs (equality compare only).

## Timing
- All outputs are registered; an event in cycle N is visible after edge N+1.
- `start` sampled at edge E: `busy`=1 after E. The first counted cycle is the cycle following E.
- End event in cycle N: after edge N+1, `done`=1, `busy`=0, and `pass`/`fail` valid. Counters are final.
- `clr` at edge E: all outputs 0 after E. `start` in the same cycle is ignored.
- Reset value of every output is 0. `rst` mid-RUN clears immediately and asynchronously, with no partial state retained.
- Saturation: a counter at all-ones stays all-ones. `wp_first_cyc` can capture the saturated value.
- Combinational path: compare + add + FSM. Watchpoint compares run in parallel; no multi-cycle paths.

## Test plan
- Basic end: wp0=0x8000_003e, `end_hits`=8; commit 3 instructions between each wp0 commit; `result_val`=1 → `done`=1, `pass`=1, `fail`=0, `wp_hit_cnt[0]`=8, `instret_cnt`=32.
- Fail path: same stimulus with `result_val`=5 at the end cycle → `fail`=1, `pass`=0. Changing `result_val` after `done` leaves the flags unchanged.
- Commit qualification: `cmt_pc` held at wp0 for 10 cycles with `cmt_valid`=0, then one valid commit → `wp_hit_cnt[0]`=1, `instret_cnt`=1, `cycle_cnt`=11.
- Multi-watchpoint: wp1 and wp2 set to the same address, wp3 disabled but matching; first hit at cycle 5 → `wp_hit_cnt[1]`=`wp_hit_cnt[2]`=1, `wp_first_cyc[1]`=`wp_first_cyc[2]`=5, `wp_seen`=4'b0110.
- Saturation: `CNT_W`=4, run 20 cycles with `end_hits`=0 → `cycle_cnt`=15 and `done`=0.
- Clear/reset priority:
  - `clr`+`start` in the same cycle from DONE → IDLE, all outputs 0.
  - `rst` asserted mid-RUN for 1 ns → all outputs 0 immediately.
  - A following `start` restarts the counts from 0.
